// File: rtl/tdm_burst_gen_pkg.sv
// Shared types and default parameters for the TDM burst generator.
// The frame-length constant reflects the fixed-slot build (TDM_SKIP_EMPTY_EN undefined).
package tdm_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 16;
  localparam int BURST_LEN_DEF = 4;
  localparam int SLOT_LEN_DEF  = 6;
  localparam int GUARD_LEN_DEF = 2;
  localparam int FRAME_LEN_DEF = 2 * (SLOT_LEN_DEF + GUARD_LEN_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SLOT0,
    GUARD0,
    SLOT1,
    GUARD1
  } tdm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdm_burst_gen_burst_fifo.sv
// Per-lane synchronous FIFO with a combinational head and a registered drop flag.
// The pointers carry an extra wrap bit, so full and empty need no separate count.
module burst_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full is judged on the pointers at the start of the cycle, so a pop never rescues a push.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      drop <= push && full;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tdm_burst_gen.sv
// Two-lane TDM burst source: lane 0 drains in SLOT0, lane 1 in SLOT1, with guard gaps.
// Define TDM_SKIP_EMPTY_EN to end a slot early once its burst is spent or its FIFO runs dry.
module tdm_burst_gen
  import tdm_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int SLOT_LEN  = SLOT_LEN_DEF,
  parameter int GUARD_LEN = GUARD_LEN_DEF
) (
  input  logic              i_ss_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_wr_data0,
  input  logic              i_wr_en0,
  input  logic [DATA_W-1:0] i_wr_data1,
  input  logic              i_wr_en1,
  output logic              o_full0,
  output logic              o_full1,
  output logic              o_drop0,
  output logic              o_drop1,
  output logic [DATA_W-1:0] o_dout0,
  output logic              o_dout0_valid,
  output logic [DATA_W-1:0] o_dout1,
  output logic              o_dout1_valid,
  output logic              o_frame_start
);

  localparam int CNT_W   = $clog2(max_int(SLOT_LEN, GUARD_LEN) + 1);
  localparam int BURST_W = $clog2(BURST_LEN + 1);

  tdm_state_e        state;
  tdm_state_e        next_state;
  logic [CNT_W-1:0]  phase_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [DATA_W-1:0] head0;
  logic [DATA_W-1:0] head1;
  logic              empty0;
  logic              empty1;
  logic              pop0;
  logic              pop1;
  logic              burst_open;
  logic              slot_last;
  logic              guard_done;

  burst_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(i_ss_clk), .rst_n(i_rst_n), .push(i_wr_en0), .push_data(i_wr_data0), .pop(pop0),
    .head(head0), .full(o_full0), .empty(empty0), .drop(o_drop0)
  );

  burst_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(i_ss_clk), .rst_n(i_rst_n), .push(i_wr_en1), .push_data(i_wr_data1), .pop(pop1),
    .head(head1), .full(o_full1), .empty(empty1), .drop(o_drop1)
  );

  assign burst_open = (burst_cnt < BURST_W'(BURST_LEN));
  assign guard_done = (phase_cnt == CNT_W'(GUARD_LEN - 1));

`ifdef TDM_SKIP_EMPTY_EN
  assign slot_last = (phase_cnt == CNT_W'(SLOT_LEN - 1)) || !burst_open ||
                     ((state == SLOT1) ? empty1 : empty0);
`else
  assign slot_last = (phase_cnt == CNT_W'(SLOT_LEN - 1));
`endif

  always_comb begin
    next_state = state;
    pop0       = 1'b0;
    pop1       = 1'b0;
    case (state)
      IDLE:    if (i_en) next_state = SLOT0;
      SLOT0: begin
        pop0 = !empty0 && burst_open;
        if (slot_last) next_state = GUARD0;
      end
      GUARD0:  if (guard_done) next_state = SLOT1;
      SLOT1: begin
        pop1 = !empty1 && burst_open;
        if (slot_last) next_state = GUARD1;
      end
      GUARD1:  if (guard_done) next_state = i_en ? SLOT0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counters restart on every state change; the popped byte lands on the lane output one cycle later.
  always_ff @(posedge i_ss_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      burst_cnt     <= '0;
      o_dout0       <= '0;
      o_dout0_valid <= 1'b0;
      o_dout1       <= '0;
      o_dout1_valid <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == IDLE)) phase_cnt <= '0;
      else                                          phase_cnt <= phase_cnt + CNT_W'(1);
      if (next_state != state)  burst_cnt <= '0;
      else if (pop0 || pop1)    burst_cnt <= burst_cnt + BURST_W'(1);
      o_frame_start <= (next_state == SLOT0) && (state != SLOT0);
      o_dout0_valid <= pop0;
      o_dout1_valid <= pop1;
      if (pop0) o_dout0 <= head0;
      if (pop1) o_dout1 <= head1;
    end
  end

endmodule

// File: tb/tb_tdm_burst_gen.sv
// Directed self-checking bench for tdm_burst_gen in its default build (fixed slot length).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tdm_burst_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] wr_data0, wr_data1;
  logic       wr_en0, wr_en1;
  logic       full0, full1, drop0, drop1;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1, frame_start;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0_data[$];
  int         q0_idx[$];
  logic [7:0] q1_data[$];
  int         q1_idx[$];
  int         q1_frame[$];
  int         fs_idx[$];
  int         overlap;

  always #5 clk = ~clk;

  tdm_burst_gen dut (
    .i_ss_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_wr_data0(wr_data0), .i_wr_en0(wr_en0), .i_wr_data1(wr_data1), .i_wr_en1(wr_en1),
    .o_full0(full0), .o_full1(full1), .o_drop0(drop0), .o_drop1(drop1),
    .o_dout0(dout0), .o_dout0_valid(valid0), .o_dout1(dout1), .o_dout1_valid(valid1),
    .o_frame_start(frame_start)
  );

  // Records every output event over n falling edges; optionally drops i_en or writes lane 0 mid-window.
  task automatic capture(input int n, input int en_off_at, input int wr0_at, input logic [7:0] wr0_val);
    int frames = 0;
    q0_data.delete(); q0_idx.delete(); q1_data.delete(); q1_idx.delete();
    q1_frame.delete(); fs_idx.delete(); overlap = 0;
    for (int s = 1; s <= n; s++) begin
      @(negedge clk);
      if (frame_start) begin frames++; fs_idx.push_back(s); end
      if (valid0) begin q0_data.push_back(dout0); q0_idx.push_back(s); end
      if (valid1) begin q1_data.push_back(dout1); q1_idx.push_back(s); q1_frame.push_back(frames); end
      if (valid0 && valid1) overlap++;
      wr_en0 = 1'b0;
      if (s == en_off_at) en = 1'b0;
      if (s == wr0_at) begin wr_en0 = 1'b1; wr_data0 = wr0_val; end
    end
    wr_en0 = 1'b0;
  endtask

  task automatic push0(input logic [7:0] d);
    @(negedge clk); wr_en1 = 1'b0; wr_en0 = 1'b1; wr_data0 = d;
  endtask

  task automatic push1(input logic [7:0] d);
    @(negedge clk); wr_en0 = 1'b0; wr_en1 = 1'b1; wr_data1 = d;
  endtask

  task automatic start_frame();
    @(negedge clk); wr_en0 = 1'b0; wr_en1 = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout0, valid0, dout1, valid1, full0, full1, drop0, drop1, frame_start} !== 25'h0) begin
      failures++; $display("[TB] FAIL reset_outputs: got %h expected 0",
        {dout0, valid0, dout1, valid1, full0, full1, drop0, drop1, frame_start});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid0, valid1, frame_start, full0, full1} !== 5'b0) begin
      failures++; $display("[TB] FAIL idle_after_reset: got %b expected 00000",
        {valid0, valid1, frame_start, full0, full1});
    end
  endtask

  task automatic test_lane0_burst();
    push0(8'h11); push0(8'h22); push0(8'h33);
    start_frame();
    capture(20, 1, 0, 8'h00);
    checks++;
    if (q0_data.size() !== 3) begin
      failures++; $display("[TB] FAIL lane0_count: got %0d expected 3", q0_data.size());
    end else begin
      checks++;
      if ({q0_data[0], q0_data[1], q0_data[2]} !== 24'h112233) begin
        failures++; $display("[TB] FAIL lane0_data: got %h expected 112233",
          {q0_data[0], q0_data[1], q0_data[2]});
      end
      checks++;
      if (q0_idx[0] !== 2 || q0_idx[2] !== 4) begin
        failures++; $display("[TB] FAIL lane0_timing: got first=%0d last=%0d expected 2 4", q0_idx[0], q0_idx[2]);
      end
    end
    checks++;
    if (q1_data.size() !== 0) begin
      failures++; $display("[TB] FAIL lane0_lane1_quiet: got %0d lane1 bytes expected 0", q1_data.size());
    end
    checks++;
    if (fs_idx.size() !== 1 || fs_idx[0] !== 1) begin
      failures++; $display("[TB] FAIL lane0_frame_start: got %0d pulses expected 1 at sample 1", fs_idx.size());
    end
  endtask

  task automatic test_refill();
    push0(8'h81);
    start_frame();
    capture(20, 1, 3, 8'h82);
    checks++;
    if (q0_data.size() !== 2) begin
      failures++; $display("[TB] FAIL refill_count: got %0d expected 2", q0_data.size());
    end else begin
      checks++;
      if ({q0_data[0], q0_data[1]} !== 16'h8182 || q0_idx[0] !== 2 || q0_idx[1] !== 5) begin
        failures++; $display("[TB] FAIL refill_data: got %h at %0d,%0d expected 8182 at 2,5",
          {q0_data[0], q0_data[1]}, q0_idx[0], q0_idx[1]);
      end
    end
  endtask

  task automatic test_lane1_burst();
    for (int i = 0; i < 6; i++) push1(8'hA0 + 8'(i));
    start_frame();
    capture(40, 40, 0, 8'h00);
    checks++;
    if (q1_data.size() !== 6) begin
      failures++; $display("[TB] FAIL lane1_count: got %0d expected 6", q1_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q1_data[i] !== 8'hA0 + 8'(i) || q1_frame[i] !== ((i < 4) ? 1 : 2)) begin
          failures++; $display("[TB] FAIL lane1_byte%0d: got %h frame %0d expected %h frame %0d",
            i, q1_data[i], q1_frame[i], 8'hA0 + 8'(i), (i < 4) ? 1 : 2);
        end
      end
      checks++;
      if (q1_idx[0] !== 10 || q1_idx[4] !== 26) begin
        failures++; $display("[TB] FAIL lane1_timing: got %0d,%0d expected 10,26", q1_idx[0], q1_idx[4]);
      end
    end
    checks++;
    if (fs_idx.size() < 2 || fs_idx[1] - fs_idx[0] !== 16) begin
      failures++; $display("[TB] FAIL frame_period: got %0d pulses, period %0d expected 16",
        fs_idx.size(), (fs_idx.size() < 2) ? 0 : fs_idx[1] - fs_idx[0]);
    end
    checks++;
    if (overlap !== 0 || q0_data.size() !== 0) begin
      failures++; $display("[TB] FAIL lane1_exclusive: got overlap %0d lane0 %0d expected 0 0", overlap, q0_data.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_en_drop_guard0();
    push1(8'hB1);
    start_frame();
    capture(30, 7, 0, 8'h00);
    checks++;
    if (fs_idx.size() !== 1) begin
      failures++; $display("[TB] FAIL guard0_frame_start: got %0d pulses expected 1", fs_idx.size());
    end
    checks++;
    if (q1_data.size() !== 1) begin
      failures++; $display("[TB] FAIL guard0_slot1_count: got %0d expected 1", q1_data.size());
    end else begin
      checks++;
      if (q1_data[0] !== 8'hB1 || q1_idx[0] !== 10) begin
        failures++; $display("[TB] FAIL guard0_slot1_data: got %h at %0d expected b1 at 10", q1_data[0], q1_idx[0]);
      end
    end
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks++;
        if (full0 !== 1'b0) begin failures++; $display("[TB] FAIL full_at_15: got %b expected 0", full0); end
      end
      if (i == 16) begin
        checks++;
        if (full0 !== 1'b1 || drop0 !== 1'b0) begin
          failures++; $display("[TB] FAIL full_at_16: got full=%b drop=%b expected 1 0", full0, drop0);
        end
      end
      wr_en0 = 1'b1; wr_data0 = 8'h40 + 8'(i);
    end
    @(negedge clk); wr_en0 = 1'b0;
    checks++;
    if (drop0 !== 1'b1) begin failures++; $display("[TB] FAIL drop_pulse: got %b expected 1", drop0); end
    @(negedge clk);
    checks++;
    if (drop0 !== 1'b0 || full0 !== 1'b1) begin
      failures++; $display("[TB] FAIL drop_single: got drop=%b full=%b expected 0 1", drop0, full0);
    end
    en = 1'b1;
    capture(70, 70, 0, 8'h00);
    checks++;
    if (q0_data.size() !== 16) begin
      failures++; $display("[TB] FAIL full_drain_count: got %0d expected 16", q0_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q0_data[i] !== 8'h40 + 8'(i)) begin
          failures++; $display("[TB] FAIL full_drain_byte%0d: got %h expected %h", i, q0_data[i], 8'h40 + 8'(i));
        end
      end
      checks++;
      if (q0_idx[0] !== 2 || q0_idx[15] !== 53) begin
        failures++; $display("[TB] FAIL full_drain_timing: got %0d,%0d expected 2,53", q0_idx[0], q0_idx[15]);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (full0 !== 1'b0) begin failures++; $display("[TB] FAIL full_cleared: got %b expected 0", full0); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen = 1'b0;
    push0(8'h71); push0(8'h72); push0(8'h73); push0(8'h74);
    start_frame();
    for (int s = 0; s < 20 && !seen; s++) begin
      @(negedge clk);
      if (valid0) seen = 1'b1;
    end
    checks++;
    if (!seen || dout0 !== 8'h71) begin
      failures++; $display("[TB] FAIL midburst_start: got seen=%b data=%h expected 1 71", seen, dout0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout0, valid0, frame_start, full0} !== 11'h0) begin
      failures++; $display("[TB] FAIL midburst_reset_outputs: got %h expected 0", {dout0, valid0, frame_start, full0});
    end
    @(negedge clk); rst_n = 1'b1;
    capture(20, 1, 2, 8'h5A);
    checks++;
    if (q0_data.size() !== 1) begin
      failures++; $display("[TB] FAIL midburst_stale: got %0d lane0 bytes expected 1", q0_data.size());
    end else begin
      checks++;
      if (q0_data[0] !== 8'h5A || q0_idx[0] !== 4) begin
        failures++; $display("[TB] FAIL midburst_new_byte: got %h at %0d expected 5a at 4", q0_data[0], q0_idx[0]);
      end
    end
    checks++;
    if (fs_idx.size() !== 1 || fs_idx[0] !== 1) begin
      failures++; $display("[TB] FAIL midburst_restart: got %0d pulses expected 1 at sample 1", fs_idx.size());
    end
  endtask

  initial begin
    test_reset();
    test_lane0_burst();
    test_refill();
    test_lane1_burst();
    test_en_drop_guard0();
    test_full_drop();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
